// File: rtl/npu_operand_feeder.sv
// Operand feeder: holds two NxN signed matrices (A, B) and streams them into an NPU core,
// column k of A and row k of B on beat k. Define NPU_FEED_TIMEOUT_EN to add a WAIT_DONE watchdog (timeout_err).

module npu_operand_feeder #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic                               wr_sel,
    input  logic [$clog2(ARRAY_SIZE)-1:0]      wr_row,
    input  logic [$clog2(ARRAY_SIZE)-1:0]      wr_col,
    input  logic signed [DATA_WIDTH-1:0]       wr_data,
    output logic                               wr_err,
    input  logic                               launch,
    output logic                               idle,
    output logic                               npu_start,
    output logic                               npu_in_valid,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   npu_a_stream,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   npu_b_stream,
    input  logic                               npu_done,
    output logic                               feed_done
`ifdef NPU_FEED_TIMEOUT_EN
    ,
    output logic                               timeout_err
`endif
);

    localparam int IDX_W = $clog2(ARRAY_SIZE);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(ARRAY_SIZE - 1);

    typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_DONE} state_t;

    state_t                        state_reg;
    logic [IDX_W-1:0]              beat_reg;
    logic                          npu_start_reg;
    logic                          npu_in_valid_reg;
    logic                          feed_done_reg;
    logic                          wr_err_reg;
    logic signed [DATA_WIDTH-1:0]  a_mem [ARRAY_SIZE][ARRAY_SIZE];
    logic signed [DATA_WIDTH-1:0]  b_mem [ARRAY_SIZE][ARRAY_SIZE];
    logic                          write_ok;
    logic                          streaming;

`ifdef NPU_FEED_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 3 * ARRAY_SIZE - 2 + ARRAY_SIZE * ARRAY_SIZE + 10;
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [TCNT_W-1:0]             wait_cnt_reg;
    logic                          timeout_err_reg;

    assign timeout_err = timeout_err_reg;
`endif

    assign write_ok  = wr_en && (state_reg == IDLE);
    assign streaming = (state_reg == STREAM);

    assign idle         = (state_reg == IDLE);
    assign npu_start    = npu_start_reg;
    assign npu_in_valid = npu_in_valid_reg;
    assign feed_done    = feed_done_reg;
    assign wr_err       = wr_err_reg;

    // Buffers only change in IDLE, so a feed always sees a stable snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                for (int j = 0; j < ARRAY_SIZE; j++) begin
                    a_mem[i][j] <= '0;
                    b_mem[i][j] <= '0;
                end
            end
        end else if (write_ok) begin
            if (wr_sel) begin
                b_mem[wr_row][wr_col] <= wr_data;
            end else begin
                a_mem[wr_row][wr_col] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            beat_reg         <= '0;
            npu_start_reg    <= 1'b0;
            npu_in_valid_reg <= 1'b0;
            feed_done_reg    <= 1'b0;
            wr_err_reg       <= 1'b0;
`ifdef NPU_FEED_TIMEOUT_EN
            wait_cnt_reg     <= '0;
            timeout_err_reg  <= 1'b0;
`endif
        end else begin
            wr_err_reg       <= wr_en && (state_reg != IDLE);
            npu_start_reg    <= 1'b0;
            npu_in_valid_reg <= 1'b0;
            feed_done_reg    <= 1'b0;
`ifdef NPU_FEED_TIMEOUT_EN
            timeout_err_reg  <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        state_reg     <= START;
                        npu_start_reg <= 1'b1;
                    end
                end
                START: begin
                    state_reg        <= STREAM;
                    beat_reg         <= '0;
                    npu_in_valid_reg <= 1'b1;
                end
                STREAM: begin
                    if (beat_reg == LAST_BEAT) begin
                        state_reg <= WAIT_DONE;
                        beat_reg  <= '0;
`ifdef NPU_FEED_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                    end else begin
                        beat_reg         <= beat_reg + 1'b1;
                        npu_in_valid_reg <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (npu_done) begin
                        state_reg     <= IDLE;
                        feed_done_reg <= 1'b1;
                    end
`ifdef NPU_FEED_TIMEOUT_EN
                    else if (wait_cnt_reg == TIMEOUT_LAST) begin
                        state_reg       <= IDLE;
                        timeout_err_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Lane r of A carries A[r][beat]; lane c of B carries B[beat][c].
    generate
        for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
            assign npu_a_stream[gi*DATA_WIDTH +: DATA_WIDTH] = streaming ? a_mem[gi][beat_reg] : '0;
            assign npu_b_stream[gi*DATA_WIDTH +: DATA_WIDTH] = streaming ? b_mem[beat_reg][gi] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_npu_operand_feeder.sv
// Testbench for npu_operand_feeder: random matrices against a matrix-level reference,
// plus directed scenarios for write rejection, held launch, same-edge write and mid-feed reset.

module tb_npu_operand_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = $clog2(N);
    localparam int TIMEOUT_CYCLES = 3 * N - 2 + N * N + 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wr_en = 1'b0;
    logic                 wr_sel = 1'b0;
    logic [IW-1:0]        wr_row = '0;
    logic [IW-1:0]        wr_col = '0;
    logic signed [DW-1:0] wr_data = '0;
    logic                 launch = 1'b0;
    logic                 npu_done = 1'b0;
    logic                 wr_err;
    logic                 idle;
    logic                 npu_start;
    logic                 npu_in_valid;
    logic                 feed_done;
    logic [N*DW-1:0]      npu_a_stream;
    logic [N*DW-1:0]      npu_b_stream;
`ifdef NPU_FEED_TIMEOUT_EN
    logic                 timeout_err;
`endif

    always #5 clk = ~clk;

    npu_operand_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_sel(wr_sel),
        .wr_row(wr_row),
        .wr_col(wr_col),
        .wr_data(wr_data),
        .wr_err(wr_err),
        .launch(launch),
        .idle(idle),
        .npu_start(npu_start),
        .npu_in_valid(npu_in_valid),
        .npu_a_stream(npu_a_stream),
        .npu_b_stream(npu_b_stream),
        .npu_done(npu_done),
        .feed_done(feed_done)
`ifdef NPU_FEED_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference matrices: what the buffers should hold after the writes issued so far.
    logic signed [DW-1:0] ref_a [N][N];
    logic signed [DW-1:0] ref_b [N][N];

    // Observations captured during one feed.
    logic signed [DW-1:0] cap_a [N][N];   // [beat][lane]
    logic signed [DW-1:0] cap_b [N][N];
    bit cap_v [N];
    bit obs_start, obs_start_iv, obs_start_idle;
    bit obs_wait_iv, obs_wait_zero, obs_wait_busy, obs_early_fd;
    bit obs_fd, obs_fd_idle, obs_fd_after, obs_start_after;
    int obs_extra_starts;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] lane(input logic [N*DW-1:0] bus, input int i);
        return bus[i*DW +: DW];
    endfunction

    task automatic clear_ref;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ref_a[r][c] = '0;
                ref_b[r][c] = '0;
            end
    endtask

    task automatic write_elem(input bit sel, input int r, input int c, input logic signed [DW-1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_row = IW'(r); wr_col = IW'(c); wr_data = d;
        tick;
        wr_en = 1'b0;
        if (sel) ref_b[r][c] = d; else ref_a[r][c] = d;
    endtask

    task automatic load_all;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                write_elem(1'b0, r, c, ref_a[r][c]);
                write_elem(1'b1, r, c, ref_b[r][c]);
            end
    endtask

    task automatic drain(output bit ok);
        npu_done = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick;
            ok = idle;
        end
        npu_done = 1'b0;
    endtask

    // Drives one launch from IDLE and records what the feeder does; checks are done by the caller.
    task automatic run_feed(input bit hold, input int delay, input bit noise,
                            input bit do_wr, input bit sel, input int row, input int col,
                            input logic signed [DW-1:0] d);
        launch = 1'b1;
        npu_done = noise;
        if (do_wr) begin
            wr_en = 1'b1; wr_sel = sel; wr_row = IW'(row); wr_col = IW'(col); wr_data = d;
            if (sel) ref_b[row][col] = d; else ref_a[row][col] = d;
        end
        tick;
        wr_en = 1'b0;
        obs_start = npu_start; obs_start_iv = npu_in_valid; obs_start_idle = idle;
        launch = hold;
        obs_extra_starts = 0;
        for (int k = 0; k < N; k++) begin
            tick;
            cap_v[k] = npu_in_valid;
            obs_extra_starts += int'(npu_start);
            for (int r = 0; r < N; r++) begin
                cap_a[k][r] = lane(npu_a_stream, r);
                cap_b[k][r] = lane(npu_b_stream, r);
            end
        end
        tick;
        npu_done = 1'b0;
        obs_wait_iv = npu_in_valid;
        obs_wait_zero = (npu_a_stream == '0) && (npu_b_stream == '0);
        obs_wait_busy = !idle;
        obs_early_fd = feed_done;
        obs_extra_starts += int'(npu_start);
        repeat (delay) begin
            tick;
            obs_wait_busy &= !idle;
            obs_early_fd |= feed_done;
        end
        npu_done = 1'b1;
        tick;
        npu_done = 1'b0;
        obs_fd = feed_done;
        obs_fd_idle = idle;
        if (!hold) launch = 1'b0;
        tick;
        obs_fd_after = feed_done;
        obs_start_after = npu_start;
        $display("feed: start=%0b valid=%0b%0b%0b%0b done_delay=%0d feed_done=%0b", obs_start,
                 cap_v[0], cap_v[1], cap_v[2], cap_v[3], delay, obs_fd);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick;
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b want 1", idle); end
        checks++;
        if ({npu_start, npu_in_valid, feed_done, wr_err} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b want 0000", {npu_start, npu_in_valid, feed_done, wr_err});
        end
        checks++;
        if ((npu_a_stream !== '0) || (npu_b_stream !== '0)) begin
            failures++; $display("FAIL reset_streams: got a=%h b=%h want 0", npu_a_stream, npu_b_stream);
        end
        rst = 1'b0;
        clear_ref;
        run_feed(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
        checks++;
        if (obs_start !== 1'b1 || obs_start_idle !== 1'b0) begin
            failures++; $display("FAIL first_launch: got start=%b idle=%b want 1/0", obs_start, obs_start_idle);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (cap_a[k] !== ref_a[0] || cap_b[k] !== ref_b[0]) begin
                failures++; $display("FAIL reset_buffers beat %0d: got a0=%0d b0=%0d want 0", k, cap_a[k][0], cap_b[k][0]);
            end
        end
    endtask

    task automatic test_directed;
        logic signed [DW-1:0] e_a0 [N] = '{8'sd1, 8'sd0, 8'sd0, 8'sd0};
        logic signed [DW-1:0] e_b0 [N] = '{8'sd4, -8'sd3, 8'sd2, 8'sd1};
        logic signed [DW-1:0] e_b3 [N] = '{-8'sd2, 8'sd0, 8'sd1, 8'sd2};
        logic signed [DW-1:0] b_rows [N][N] = '{'{8'sd4, -8'sd3, 8'sd2, 8'sd1}, '{8'sd0, 8'sd5, -8'sd1, 8'sd7},
                                              '{8'sd1, 8'sd2, 8'sd3, 8'sd4}, '{-8'sd2, 8'sd0, 8'sd1, 8'sd2}};
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ref_a[r][c] = (r == c) ? 8'sd1 : 8'sd0;
                ref_b[r][c] = b_rows[r][c];
            end
        load_all;
        run_feed(1'b0, 2, 1'b0, 1'b0, 1'b0, 0, 0, '0);
        checks++;
        if (obs_start !== 1'b1 || obs_start_iv !== 1'b0) begin
            failures++; $display("FAIL dir_start: got start=%b valid=%b want 1/0", obs_start, obs_start_iv);
        end
        checks++;
        if (cap_a[0] !== e_a0 || cap_b[0] !== e_b0) begin
            failures++; $display("FAIL dir_beat0: got a=%0d,%0d,%0d,%0d b=%0d,%0d,%0d,%0d want a=1,0,0,0 b=4,-3,2,1",
                                 cap_a[0][0], cap_a[0][1], cap_a[0][2], cap_a[0][3],
                                 cap_b[0][0], cap_b[0][1], cap_b[0][2], cap_b[0][3]);
        end
        checks++;
        if (cap_b[3] !== e_b3) begin
            failures++; $display("FAIL dir_beat3: got b=%0d,%0d,%0d,%0d want -2,0,1,2",
                                 cap_b[3][0], cap_b[3][1], cap_b[3][2], cap_b[3][3]);
        end
        checks++;
        if (!(cap_v[0] && cap_v[1] && cap_v[2] && cap_v[3]) || obs_wait_iv || !obs_wait_zero) begin
            failures++; $display("FAIL dir_valid: got beats=%b%b%b%b wait_valid=%b wait_zero=%b want 1111/0/1",
                                 cap_v[0], cap_v[1], cap_v[2], cap_v[3], obs_wait_iv, obs_wait_zero);
        end
        checks++;
        if (obs_fd !== 1'b1 || obs_fd_idle !== 1'b1 || obs_early_fd || obs_fd_after || !obs_wait_busy) begin
            failures++; $display("FAIL dir_feed_done: got fd=%b idle=%b early=%b after=%b busy=%b want 1/1/0/0/1",
                                 obs_fd, obs_fd_idle, obs_early_fd, obs_fd_after, obs_wait_busy);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            int delay;
            bit noise;
            bit bad;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    ref_a[r][c] = DW'($urandom);
                    ref_b[r][c] = DW'($urandom);
                end
            load_all;
            delay = $urandom_range(0, 5);
            noise = 1'($urandom_range(0, 1));
            run_feed(1'b0, delay, noise, 1'b0, 1'b0, 0, 0, '0);
            for (int k = 0; k < N; k++) begin
                bad = !cap_v[k];
                for (int i = 0; i < N; i++)
                    if (cap_a[k][i] !== ref_a[i][k] || cap_b[k][i] !== ref_b[k][i]) bad = 1'b1;
                checks++;
                if (bad) begin
                    failures++; $display("FAIL rand_beat it%0d k%0d: got a0=%0d b0=%0d valid=%b want a0=%0d b0=%0d valid=1",
                                         it, k, cap_a[k][0], cap_b[k][0], cap_v[k], ref_a[0][k], ref_b[k][0]);
                end
            end
            // Product the core would form from the stream versus A*B from the reference.
            bad = 1'b0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    int got = 0;
                    int want = 0;
                    for (int k = 0; k < N; k++) begin
                        got  += int'(cap_a[k][r]) * int'(cap_b[k][c]);
                        want += int'(ref_a[r][k]) * int'(ref_b[k][c]);
                    end
                    if (got != want) bad = 1'b1;
                end
            checks++;
            if (bad) begin failures++; $display("FAIL rand_product it%0d: got mismatching C want A*B", it); end
            checks++;
            if (obs_start !== 1'b1 || obs_fd !== 1'b1 || obs_early_fd || obs_fd_after || obs_start_after || !obs_wait_busy) begin
                failures++; $display("FAIL rand_ctrl it%0d: got start=%b fd=%b early=%b after=%b restart=%b busy=%b want 1/1/0/0/0/1",
                                     it, obs_start, obs_fd, obs_early_fd, obs_fd_after, obs_start_after, obs_wait_busy);
            end
        end
    endtask

    task automatic test_write_reject;
        bit ok;
        bit bad;
        launch = 1'b1;
        tick;
        launch = 1'b0;
        tick;
        wr_en = 1'b1; wr_sel = 1'($urandom); wr_row = IW'($urandom); wr_col = IW'($urandom); wr_data = 8'sh7F;
        launch = 1'b1;
        tick;
        wr_en = 1'b0;
        launch = 1'b0;
        $display("write during stream: sel=%0d row=%0d col=%0d data=7f", wr_sel, wr_row, wr_col);
        checks++;
        if (wr_err !== 1'b1) begin failures++; $display("FAIL wr_err_pulse: got %b want 1", wr_err); end
        tick;
        checks++;
        if (wr_err !== 1'b0) begin failures++; $display("FAIL wr_err_width: got %b want 0", wr_err); end
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL reject_drain: got busy want idle within 20 cycles"); end
        tick;
        tick;
        checks++;
        if (npu_start !== 1'b0 || idle !== 1'b1) begin
            failures++; $display("FAIL launch_not_queued: got start=%b idle=%b want 0/1", npu_start, idle);
        end
        write_elem(1'b0, 1, 1, ref_a[1][1]);
        checks++;
        if (wr_err !== 1'b0) begin failures++; $display("FAIL idle_write_err: got %b want 0", wr_err); end
        run_feed(1'b0, 1, 1'b0, 1'b0, 1'b0, 0, 0, '0);
        bad = 1'b0;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++)
                if (cap_a[k][i] !== ref_a[i][k] || cap_b[k][i] !== ref_b[k][i]) bad = 1'b1;
        checks++;
        if (bad) begin failures++; $display("FAIL reject_unchanged: got altered stream want original buffers"); end
    endtask

    task automatic test_launch_held;
        int nstart = 0;
        int nbeats = 0;
        bit ok;
        run_feed(1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 0, '0);
        checks++;
        if (obs_start !== 1'b1 || obs_extra_starts != 0 || obs_fd !== 1'b1 || obs_start_after !== 1'b1) begin
            failures++; $display("FAIL held_first: got start=%b extra=%0d fd=%b restart=%b want 1/0/1/1",
                                 obs_start, obs_extra_starts, obs_fd, obs_start_after);
        end
        launch = 1'b0;
        repeat (N + 1) begin
            tick;
            nstart += int'(npu_start);
            nbeats += int'(npu_in_valid);
        end
        checks++;
        if (nstart != 0 || nbeats != N) begin
            failures++; $display("FAIL held_second: got starts=%0d beats=%0d want 0/%0d", nstart, nbeats, N);
        end
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL held_drain: got busy want idle within 20 cycles"); end
    endtask

    task automatic test_same_edge;
        bit bad = 1'b0;
        bit sel = 1'($urandom);
        int row = $urandom_range(0, N - 1);
        int col = $urandom_range(0, N - 1);
        logic signed [DW-1:0] d = DW'($urandom);
        run_feed(1'b0, 0, 1'b0, 1'b1, sel, row, col, d);
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++)
                if (cap_a[k][i] !== ref_a[i][k] || cap_b[k][i] !== ref_b[k][i]) bad = 1'b1;
        checks++;
        if (bad || obs_start !== 1'b1) begin
            failures++; $display("FAIL same_edge_write: got stale stream or start=%b want write %0d at sel%0d[%0d][%0d] visible",
                                 obs_start, d, sel, row, col);
        end
    endtask

    task automatic test_reset_mid;
        bit bad = 1'b0;
        launch = 1'b1;
        tick;
        launch = 1'b0;
        repeat (3) tick;
        checks++;
        if (npu_in_valid !== 1'b1) begin failures++; $display("FAIL mid_beat2_valid: got %b want 1", npu_in_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (idle !== 1'b1 || {npu_start, npu_in_valid, feed_done, wr_err} !== 4'b0000 ||
            npu_a_stream !== '0 || npu_b_stream !== '0) begin
            failures++; $display("FAIL mid_reset_outputs: got idle=%b flags=%b a=%h b=%h want 1/0000/0/0",
                                 idle, {npu_start, npu_in_valid, feed_done, wr_err}, npu_a_stream, npu_b_stream);
        end
        tick;
        tick;
        checks++;
        if (feed_done !== 1'b0 || idle !== 1'b1) begin
            failures++; $display("FAIL mid_reset_hold: got fd=%b idle=%b want 0/1", feed_done, idle);
        end
        rst = 1'b0;
        clear_ref;
        run_feed(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++)
                if (cap_a[k][i] !== ref_a[i][k] || cap_b[k][i] !== ref_b[k][i]) bad = 1'b1;
        checks++;
        if (bad || obs_start !== 1'b1 || obs_fd !== 1'b1) begin
            failures++; $display("FAIL post_reset_feed: got start=%b fd=%b zeroed=%b want 1/1/1", obs_start, obs_fd, !bad);
        end
    endtask

`ifdef NPU_FEED_TIMEOUT_EN
    task automatic test_timeout;
        int first = 0;
        bit idle_at = 1'b0;
        bit fd_seen = 1'b0;
        launch = 1'b1;
        tick;
        launch = 1'b0;
        repeat (N) tick;
        tick;
        for (int i = 1; i <= TIMEOUT_CYCLES + 5; i++) begin
            tick;
            fd_seen |= feed_done;
            if (timeout_err && first == 0) begin
                first = i;
                idle_at = idle;
            end
        end
        $display("timeout: pulse after %0d cycles in WAIT_DONE", first);
        checks++;
        if (first != TIMEOUT_CYCLES || !idle_at || fd_seen) begin
            failures++; $display("FAIL timeout: got cycles=%0d idle=%b fd=%b want %0d/1/0", first, idle_at, fd_seen, TIMEOUT_CYCLES);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_write_reject;
        test_launch_held;
        test_same_edge;
        test_reset_mid;
`ifdef NPU_FEED_TIMEOUT_EN
        test_timeout;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
